lsu_itf_arbiter: RTL
====================

Name: lsu_itf_arbiter

Overview:
- Merges two LSU initiator ports (master 0, master 1) onto one downstream LSU target port (`lsu_req_t`/`lsu_ack_t`, SOPHON_PKG).
- Used where two request sources share one memory channel, e.g. core LSU plus a debug/DMA engine into the DTCM or external-memory channel.
- Round-robin arbitration; grant is locked until the transfer completes.
- Optional timeout returns an error ack if the target never responds.

Parameters:
- TIMEOUT_CYCLES, 256, cycles in BUSY before error completion; 0 disables the timeout.
- CNT_W, 16, width of the timeout counter; must satisfy TIMEOUT_CYCLES < 2^CNT_W.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  reset, synchronous, active-high
- lsu_req_m0_i  input  SOPHON_PKG::lsu_req_t  master 0 request
- lsu_ack_m0_o  output  SOPHON_PKG::lsu_ack_t  master 0 response
- lsu_req_m1_i  input  SOPHON_PKG::lsu_req_t  master 1 request
- lsu_ack_m1_o  output  SOPHON_PKG::lsu_ack_t  master 1 response
- lsu_req_o  output  SOPHON_PKG::lsu_req_t  request to target
- lsu_ack_i  input  SOPHON_PKG::lsu_ack_t  response from target
- timeout_o  output  1  one-cycle pulse when a timeout completion occurs

Behaviour:
- Protocol:
  - A master holds req=1 with stable we/addr/wdata/amo/strb/size until the cycle it sees ack=1.
  - ack is a single-cycle pulse. The transfer completes on the cycle where req and ack are both high.
  - The target may ack in the same cycle as req (zero wait) or any later cycle.
- Reset (rst_i sampled high at a clock edge):
  - state=IDLE, prio=0 (master 0 favoured), timeout counter=0.
  - All outputs combinationally derived. With no requests: lsu_req_o all fields 0, both acks all fields 0, timeout_o=0.
- FSM IDLE:
  - Candidate = requesting master. If both request, candidate = prio.
  - Candidate request is forwarded combinationally to lsu_req_o (zero added latency).
  - If lsu_ack_i.ack is high the same cycle: route ack/error/rdata to the candidate, set prio to the other master, stay IDLE.
  - Otherwise: latch grant=candidate, go BUSY, counter=1.
- FSM BUSY:
  - lsu_req_o = request of the granted master. The other master's request is ignored even if it arrives earlier.
  - On lsu_ack_i.ack: forward ack/error/rdata to the granted master, prio = other master, go IDLE, counter=0.
  - If TIMEOUT_CYCLES>0 and counter==TIMEOUT_CYCLES with no ack that cycle:
    - Granted master gets ack=1, error=1, rdata=0 for one cycle; timeout_o=1.
    - lsu_req_o.req drops to 0 on the next cycle; prio flips; go IDLE.
  - Otherwise the counter increments by 1 per cycle and saturates.
  - Ack arriving on the timeout cycle: ack wins, error=lsu_ack_i.error, no timeout_o.
- Non-granted master: ack=0, error=0, rdata=0 at all times.
- lsu_ack_i.ack while nothing is forwarded (stray ack): ignored, no master acked, no state change.
- Granted master drops req in BUSY before ack (protocol violation): lsu_req_o.req follows it to 0 and the FSM stays BUSY until ack or timeout. This is defined behaviour, not a hang.
- Back-to-back:
  - After a completion in IDLE or BUSY, a new request can be forwarded in the very next cycle.
  - With both masters continuously requesting, grants alternate 0,1,0,1.
- Reset asserted mid-transfer: FSM returns to IDLE next edge, counter=0, prio=0. No ack is generated for the aborted transfer.

Test Plan:
- Single master, zero-wait target:
  - Stimulus: m0 req addr=0x10004 we=0, target acks same cycle with rdata=0xDEADBEEF.
  - Required: m0 ack=1, rdata=0xDEADBEEF in cycle 0; lsu_req_o.addr=0x10004 in that cycle; state stays IDLE.
- Contention, round-robin:
  - Stimulus: m0 and m1 both req continuously; target acks every transfer with 2 wait cycles.
  - Required: grants alternate m0,m1,m0,m1; each completion takes 3 cycles; first grant is m0 after reset.
- Grant lock:
  - Stimulus: m1 granted and BUSY; m0 asserts req; target acks m1 3 cycles later.
  - Required: lsu_req_o fields equal m1's for all 3 cycles; m0 is forwarded in the cycle after the m1 ack.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=4; m0 write, target never acks.
  - Required: m0 ack=1 error=1 rdata=0 and timeout_o=1 on the 4th BUSY cycle; lsu_req_o.req=0 the next cycle; the next grant goes to m1 if it is pending.
- Ack at timeout edge:
  - Stimulus: TIMEOUT_CYCLES=4; target acks with error=0 on the 4th BUSY cycle.
  - Required: error=0, timeout_o=0.
- Reset mid-transfer:
  - Stimulus: rst_i=1 for one cycle while BUSY with m1.
  - Required: next cycle IDLE; no ack to m1; with both requesting afterwards, m0 is granted first.

Source files
------------

// File: rtl/lsu_itf_arbiter.sv
`default_nettype none
// lsu_itf_arbiter: two-initiator round-robin arbiter onto one LSU target port,
// with grant lock until completion and an optional no-response timeout.
module lsu_itf_arbiter #(
   parameter int TIMEOUT_CYCLES = 256,
   parameter int CNT_W          = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   // master 0 request / response
   input  logic        lsu_req_m0_req_i,
   input  logic        lsu_req_m0_we_i,
   input  logic [31:0] lsu_req_m0_addr_i,
   input  logic [31:0] lsu_req_m0_wdata_i,
   input  logic [3:0]  lsu_req_m0_amo_i,
   input  logic [3:0]  lsu_req_m0_strb_i,
   input  logic [1:0]  lsu_req_m0_size_i,
   output logic        lsu_ack_m0_ack_o,
   output logic        lsu_ack_m0_error_o,
   output logic [31:0] lsu_ack_m0_rdata_o,
   // master 1 request / response
   input  logic        lsu_req_m1_req_i,
   input  logic        lsu_req_m1_we_i,
   input  logic [31:0] lsu_req_m1_addr_i,
   input  logic [31:0] lsu_req_m1_wdata_i,
   input  logic [3:0]  lsu_req_m1_amo_i,
   input  logic [3:0]  lsu_req_m1_strb_i,
   input  logic [1:0]  lsu_req_m1_size_i,
   output logic        lsu_ack_m1_ack_o,
   output logic        lsu_ack_m1_error_o,
   output logic [31:0] lsu_ack_m1_rdata_o,
   // target request / response
   output logic        lsu_req_req_o,
   output logic        lsu_req_we_o,
   output logic [31:0] lsu_req_addr_o,
   output logic [31:0] lsu_req_wdata_o,
   output logic [3:0]  lsu_req_amo_o,
   output logic [3:0]  lsu_req_strb_o,
   output logic [1:0]  lsu_req_size_o,
   input  logic        lsu_ack_ack_i,
   input  logic        lsu_ack_error_i,
   input  logic [31:0] lsu_ack_rdata_i,
   output logic        timeout_o
);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state, state_nxt;
   logic             prio, prio_nxt;
   logic             grant, grant_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;

   logic sel;
   logic fwd;
   logic done_ack;
   logic tmo;
   logic complete;

   // In BUSY the granted master stays forwarded even if it drops req early.
   always_comb begin
      sel = grant;
      fwd = 1'b1;
      if (state == IDLE) begin
         fwd = lsu_req_m0_req_i | lsu_req_m1_req_i;
         if (lsu_req_m0_req_i && lsu_req_m1_req_i) begin
            sel = prio;
         end else begin
            sel = lsu_req_m1_req_i;
         end
      end
   end

   always_comb begin
      tmo = 1'b0;
      if (TIMEOUT_CYCLES > 0) begin
         tmo = (state == BUSY) && (cnt == TMO_VAL) && !lsu_ack_ack_i;
      end
   end

   assign done_ack  = fwd & lsu_ack_ack_i;
   assign complete  = done_ack | tmo;
   assign timeout_o = tmo;

   always_comb begin
      lsu_req_req_o   = 1'b0;
      lsu_req_we_o    = 1'b0;
      lsu_req_addr_o  = '0;
      lsu_req_wdata_o = '0;
      lsu_req_amo_o   = '0;
      lsu_req_strb_o  = '0;
      lsu_req_size_o  = '0;
      if (fwd) begin
         if (sel) begin
            lsu_req_req_o   = lsu_req_m1_req_i;
            lsu_req_we_o    = lsu_req_m1_we_i;
            lsu_req_addr_o  = lsu_req_m1_addr_i;
            lsu_req_wdata_o = lsu_req_m1_wdata_i;
            lsu_req_amo_o   = lsu_req_m1_amo_i;
            lsu_req_strb_o  = lsu_req_m1_strb_i;
            lsu_req_size_o  = lsu_req_m1_size_i;
         end else begin
            lsu_req_req_o   = lsu_req_m0_req_i;
            lsu_req_we_o    = lsu_req_m0_we_i;
            lsu_req_addr_o  = lsu_req_m0_addr_i;
            lsu_req_wdata_o = lsu_req_m0_wdata_i;
            lsu_req_amo_o   = lsu_req_m0_amo_i;
            lsu_req_strb_o  = lsu_req_m0_strb_i;
            lsu_req_size_o  = lsu_req_m0_size_i;
         end
      end
   end

   // A timeout completion reports error with zero read data.
   always_comb begin
      lsu_ack_m0_ack_o   = complete & !sel;
      lsu_ack_m0_error_o = !sel & (done_ack ? lsu_ack_error_i : tmo);
      lsu_ack_m0_rdata_o = (done_ack && !sel) ? lsu_ack_rdata_i : '0;
      lsu_ack_m1_ack_o   = complete & sel;
      lsu_ack_m1_error_o = sel & (done_ack ? lsu_ack_error_i : tmo);
      lsu_ack_m1_rdata_o = (done_ack && sel) ? lsu_ack_rdata_i : '0;
   end

   always_comb begin
      state_nxt = state;
      prio_nxt  = prio;
      grant_nxt = grant;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (fwd) begin
               if (lsu_ack_ack_i) begin
                  prio_nxt = ~sel;
               end else begin
                  state_nxt = BUSY;
                  grant_nxt = sel;
                  cnt_nxt   = CNT_ONE;
               end
            end
         end
         BUSY: begin
            if (complete) begin
               state_nxt = IDLE;
               prio_nxt  = ~grant;
               cnt_nxt   = '0;
            end else if (cnt != CNT_MAX) begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= IDLE;
         prio  <= 1'b0;
         grant <= 1'b0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         prio  <= prio_nxt;
         grant <= grant_nxt;
         cnt   <= cnt_nxt;
      end
   end

endmodule
`default_nettype wire
